// File: rtl/instr_sequencer.sv
// Fetch/decode sequencer for the 8-bit W-register datapath: fetches 16-bit words, drives the ALU and owns the PC.
// Optional fetch watchdog enabled by defining SEQ_FETCH_TIMEOUT_EN.
module instr_sequencer #(
  parameter int              PC_W           = 17,
  parameter logic [PC_W-1:0] RESET_PC       = {PC_W{1'b0}},
  parameter int              TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            zero,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_req,
  input  logic            mem_ack,
  input  logic [15:0]     mem_data,
  output logic [3:0]      inst,
  output logic [7:0]      b,
  output logic            w_en,
  output logic            halted,
  output logic            err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0] PC_TWO = {{(PC_W-2){1'b0}}, 2'b10};

  logic [1:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_word;
  logic            r_mem_req;
  logic [3:0]      r_inst;
  logic [7:0]      r_b;
  logic            r_w_en;
  logic            r_halted;
  logic [3:0]      w_op;
  logic [PC_W-1:0] w_pc_next;

`ifdef SEQ_FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;
  logic             r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign mem_addr = r_pc;
  assign mem_req  = r_mem_req;
  assign inst     = r_inst;
  assign b        = r_b;
  assign w_en     = r_w_en;
  assign halted   = r_halted;
  assign w_op     = r_word[15:12];

  // Next PC for the instruction latched in r_word; zero is sampled during EXEC.
  always_comb begin
    w_pc_next = r_pc + PC_ONE;
    case (w_op)
      4'hD:    w_pc_next = r_pc;
      4'hE:    w_pc_next = zero ? (r_pc + PC_TWO) : (r_pc + PC_ONE);
      4'hF:    w_pc_next = {{(PC_W-12){1'b0}}, r_word[11:0]};
      default: w_pc_next = r_pc + PC_ONE;
    endcase
  end

  // Sequencer FSM; ALU outputs are decoded straight from mem_data on the ack edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_word    <= 16'h0000;
      r_mem_req <= 1'b0;
      r_inst    <= 4'h0;
      r_b       <= 8'h00;
      r_w_en    <= 1'b0;
      r_halted  <= 1'b0;
`ifdef SEQ_FETCH_TIMEOUT_EN
      r_tmo     <= {TMO_W{1'b0}};
      r_err     <= 1'b0;
`endif
    end else begin
`ifdef SEQ_FETCH_TIMEOUT_EN
      if (r_state != S_FETCH) begin
        r_tmo <= {TMO_W{1'b0}};
      end
`endif
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state   <= S_FETCH;
            r_mem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            r_word    <= mem_data;
            r_mem_req <= 1'b0;
            r_state   <= S_EXEC;
            if (mem_data[15:12] <= 4'hA) begin
              r_inst <= mem_data[15:12];
              r_b    <= mem_data[7:0];
              r_w_en <= 1'b1;
            end
`ifdef SEQ_FETCH_TIMEOUT_EN
          end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            r_err     <= 1'b1;
            r_halted  <= 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= S_HALT;
          end else begin
            r_tmo <= r_tmo + {{(TMO_W-1){1'b0}}, 1'b1};
`endif
          end
        end
        S_EXEC: begin
          r_w_en <= 1'b0;
          r_pc   <= w_pc_next;
          if (w_op == 4'hD) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (run) begin
            r_state   <= S_FETCH;
            r_mem_req <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HALT: begin
          r_mem_req <= 1'b0;
          r_halted  <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus random programs against a PC/operand model.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        zero = 1'b0;
  logic [16:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = 16'h0000;
  logic [3:0]  inst;
  logic [7:0]  b;
  logic        w_en, halted, err;

  logic        run2 = 1'b0;
  logic [16:0] mem_addr2;
  logic        mem_req2;
  logic        ack2 = 1'b1;
  logic [15:0] data2 = 16'hB000;
  logic [3:0]  inst2;
  logic [7:0]  b2;
  logic        w_en2, halted2, err2;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [0:4095];
  logic [16:0] m_pc;
  logic [3:0]  m_inst;
  logic [7:0]  m_b;

  instr_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .zero(zero),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data),
    .inst(inst), .b(b), .w_en(w_en), .halted(halted), .err(err)
  );

  instr_sequencer #(.RESET_PC(17'h1FFFF)) dut2 (
    .clk(clk), .reset(reset), .run(run2), .zero(zero),
    .mem_addr(mem_addr2), .mem_req(mem_req2), .mem_ack(ack2), .mem_data(data2),
    .inst(inst2), .b(b2), .w_en(w_en2), .halted(halted2), .err(err2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic restart();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_pc   = 17'h00000;
    m_inst = 4'h0;
    m_b    = 8'h00;
  endtask

  // One full instruction: wait for the request, stall wt cycles, ack, check EXEC, update the model.
  task automatic do_instr(input int wt, input logic zv);
    int n;
    logic [15:0] word;
    logic [3:0]  op;
    n = 0;
    while (mem_req !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req", {31'd0, mem_req}, 32'd1);
    chk("fetch_addr", {15'd0, mem_addr}, {15'd0, m_pc});
    chk("fetch_wen_low", {31'd0, w_en}, 32'd0);
    word = rom[m_pc[11:0]];
    for (int i = 0; i < wt; i++) begin
      @(negedge clk);
      chk("wait_req", {31'd0, mem_req}, 32'd1);
      chk("wait_addr", {15'd0, mem_addr}, {15'd0, m_pc});
      chk("wait_wen", {31'd0, w_en}, 32'd0);
      chk("wait_err", {31'd0, err}, 32'd0);
    end
    mem_ack  = 1'b1;
    mem_data = word;
    zero     = zv;
    @(negedge clk);
    mem_ack  = 1'b0;
    mem_data = 16'($urandom);
    op = word[15:12];
    if (op <= 4'hA) begin
      m_inst = op;
      m_b    = word[7:0];
    end
    chk("exec_wen", {31'd0, w_en}, (op <= 4'hA) ? 32'd1 : 32'd0);
    chk("exec_inst", {28'd0, inst}, {28'd0, m_inst});
    chk("exec_b", {24'd0, b}, {24'd0, m_b});
    chk("exec_req", {31'd0, mem_req}, 32'd0);
    chk("exec_halted", {31'd0, halted}, 32'd0);
    case (op)
      4'hD:    m_pc = m_pc;
      4'hE:    m_pc = m_pc + (zv ? 17'd2 : 17'd1);
      4'hF:    m_pc = {5'b00000, word[11:0]};
      default: m_pc = m_pc + 17'd1;
    endcase
    @(negedge clk);
    if (op == 4'hD) chk("halt_entry", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 4096; i++) rom[i] = 16'hB000;

    // Reset state
    @(negedge clk);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_inst", {28'd0, inst}, 32'd0);
    chk("rst_b", {24'd0, b}, 32'd0);
    chk("rst_wen", {31'd0, w_en}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_addr", {15'd0, mem_addr}, 32'd0);
    chk("rst_addr2", {15'd0, mem_addr2}, 32'h1FFFF);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_no_req", {31'd0, mem_req}, 32'd0);

    // Zero-wait two ALU instructions
    m_pc = 17'd0; m_inst = 4'h0; m_b = 8'h00;
    rom[0] = 16'h100A; rom[1] = 16'h2003;
    run = 1'b1;
    do_instr(0, 1'b0);
    chk("alu1_inst", {28'd0, inst}, 32'd1);
    do_instr(0, 1'b0);
    chk("alu2_b", {24'd0, b}, 32'd3);
    chk("pc_after2", {15'd0, m_pc}, 32'd2);
    do_instr(0, 1'b0);

    // Delayed ack
    restart();
    do_instr(3, 1'b0);

    // SKZ taken and not taken
    rom[0] = 16'hE000;
    restart();
    do_instr(0, 1'b1);
    do_instr(0, 1'b0);
    restart();
    do_instr(0, 1'b0);
    do_instr(0, 1'b0);

    // GOTO
    rom[0] = 16'hF123;
    restart();
    do_instr(0, 1'b0);
    chk("goto_pc", {15'd0, m_pc}, 32'h123);
    do_instr(1, 1'b0);

`ifdef SEQ_FETCH_TIMEOUT_EN
    restart();
    do_instr(15, 1'b0);
`endif

    // Random programs with random stalls and zero flag
    for (int i = 0; i < 4096; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hD) w[15:12] = 4'h3;
      rom[i] = w;
    end
    restart();
    for (int k = 0; k < 300; k++) begin
      do_instr(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset while a fetch is outstanding
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async_req", {31'd0, mem_req}, 32'd0);
    chk("async_inst", {28'd0, inst}, 32'd0);
    chk("async_b", {24'd0, b}, 32'd0);
    chk("async_wen", {31'd0, w_en}, 32'd0);
    chk("async_halted", {31'd0, halted}, 32'd0);
    chk("async_addr", {15'd0, mem_addr}, 32'd0);

    // PC wrap, HALT on the second instance
    run = 1'b0;
    run2 = 1'b1;
    data2 = 16'hB000;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("wrap_req", {31'd0, mem_req2}, 32'd1);
    chk("wrap_addr0", {15'd0, mem_addr2}, 32'h1FFFF);
    @(negedge clk);
    chk("wrap_nop_wen", {31'd0, w_en2}, 32'd0);
    @(negedge clk);
    chk("wrap_addr1", {15'd0, mem_addr2}, 32'h00000);
    data2 = 16'hD000;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      chk("halt_flag", {31'd0, halted2}, 32'd1);
      chk("halt_no_req", {31'd0, mem_req2}, 32'd0);
      chk("halt_addr", {15'd0, mem_addr2}, 32'd0);
      @(negedge clk);
    end

    // SKZ wrap: 0x1FFFF + 2 -> 0x00001
    data2 = 16'hE000;
    zero = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("skz_wrap_a", {15'd0, mem_addr2}, 32'h1FFFF);
    @(negedge clk);
    @(negedge clk);
    chk("skz_wrap_b", {15'd0, mem_addr2}, 32'h00001);
    run2 = 1'b0;

    // Fetch with no ack: watchdog or indefinite wait
    run = 1'b1;
    restart();
    @(negedge clk);
    chk("noack_req", {31'd0, mem_req}, 32'd1);
`ifdef SEQ_FETCH_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk("tmo_pending", {30'd0, err, mem_req}, 32'd1);
    end
    @(negedge clk);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_halted", {31'd0, halted}, 32'd1);
    chk("tmo_req", {31'd0, mem_req}, 32'd0);
`else
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("stall_req", {31'd0, mem_req}, 32'd1);
      chk("stall_err", {31'd0, err}, 32'd0);
      chk("stall_addr", {15'd0, mem_addr}, 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/decode front end for the 8-bit W-register datapath: `pcounter` → `alu` → `w_reg`.
- Requests 16-bit program words from program memory over a req/ack handshake.
- Decodes each word into the ALU's `inst[3:0]` opcode and `b[7:0]` literal, and strobes `w_en` so `w_reg` captures `ans`.
- Owns the 17-bit program counter, replacing the free-running `pcounter` count with fetch-controlled sequencing: increment, skip and goto.

Parameters:
- `PC_W`, 17, program counter / memory address width.
- `RESET_PC`, 0, PC value loaded on reset.
- `TIMEOUT_CYCLES`, 16, fetch watchdog limit. Used only with `SEQ_FETCH_TIMEOUT_EN`.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `run` in 1: level; enables instruction fetching.
- `zero` in 1: zero flag from the datapath (W == 0).
- `mem_addr` out `PC_W`: program memory address.
- `mem_req` out 1: fetch request.
- `mem_ack` in 1: memory acknowledge; `mem_data` is valid in the same cycle.
- `mem_data` in 16: instruction word. `[15:12]` opcode, `[11:0]` payload.
- `inst` out 4: ALU opcode, registered.
- `b` out 8: ALU literal operand, registered.
- `w_en` out 1: one-cycle W-register load strobe.
- `halted` out 1: sequencer is stopped on HALT or error.
- `err` out 1: fetch timeout flag. Constant 0 when the feature is compiled out.

Behaviour:
- Reset (`reset`=0, async):
  - PC=`RESET_PC`.
  - `mem_req`=0, `inst`=0, `b`=0, `w_en`=0, `halted`=0, `err`=0.
  - State=IDLE.
  - Reset asserted mid-handshake drops `mem_req` immediately.
- `mem_addr` = PC at all times (combinational from the PC register).
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: `mem_req`=0. Go to FETCH on the first edge where `run`=1.
- FETCH:
  - `mem_req`=1; `mem_addr` held stable until ack.
  - On an edge with `mem_ack`=1: latch `mem_data`, go to EXEC.
  - `mem_ack` while `mem_req`=0 is ignored.
- EXEC (exactly 1 cycle): outputs are registered on entry; `w_en` is high only during EXEC.
  - Opcode 0x0–0xA (ALU ops):
    - `inst`=`op`, `b`=`payload[7:0]`, `w_en`=1.
    - PC=PC+1.
  - Opcode 0xB, 0xC (NOP): `w_en`=0, PC+1. `inst`/`b` keep their previous values.
  - Opcode 0xD (HALT): `w_en`=0, PC unchanged, go to HALT.
  - Opcode 0xE (SKZ):
    - `w_en`=0.
    - `zero` is sampled in the EXEC cycle.
    - PC+2 if `zero`=1, else PC+1.
  - Opcode 0xF (GOTO): `w_en`=0, PC={5'b0, `payload`[11:0]}.
- After EXEC: go to FETCH if `run`=1, else IDLE. `run` is only examined at instruction boundaries; a fetch in progress is never abandoned.
- HALT: `halted`=1, `mem_req`=0. Exited only by reset.
- Throughput: 2 cycles per instruction with a zero-wait memory (ack in the first FETCH cycle); +1 cycle per wait cycle.
- PC arithmetic is modulo 2^`PC_W`: 0x1FFFF+1 → 0x00000, and 0x1FFFF+2 (SKZ) → 0x00001.
- `inst`/`b` always hold the last ALU instruction so the combinational ALU input stays stable; `w_en` is the sole qualifier.

Optional Feature:
- Macro: `SEQ_FETCH_TIMEOUT_EN`.
- Defined:
  - A counter clears on FETCH entry and increments each FETCH cycle without `mem_ack`.
  - When it reaches `TIMEOUT_CYCLES`: `err`=1, `halted`=1, `mem_req`=0, go to HALT.
  - An ack arriving on the same edge the count reaches the limit wins: the fetch completes and no error is raised.
- Undefined: no counter; `err` tied 0; FETCH waits indefinitely.

Test Plan:
- Reset, `run`=1, zero-wait memory; ROM[0]=0x100A, ROM[1]=0x2003.
  → `w_en` pulses 2 cycles apart: `inst`=1,`b`=10, then `inst`=2,`b`=3. `mem_addr` goes 0,1,2.
- Ack delayed 3 cycles on ROM[0].
  → `mem_req` high 4 cycles, `mem_addr` stable at 0, exactly one `w_en` pulse.
- ROM[0]=0xE000 with `zero`=1 → next fetch at 2. Repeat with `zero`=0 → next fetch at 1.
- ROM[0]=0xF123 → next `mem_addr`=0x00123.
- Force PC=0x1FFFF via `RESET_PC` with a NOP → next `mem_addr`=0.
  Then HALT word → `halted`=1, `mem_req` stays 0 for 20 cycles.
- Assert `reset` low while `mem_req`=1 → all outputs 0 immediately, without waiting for a clock edge.
  With `SEQ_FETCH_TIMEOUT_EN` and no ack → `err`=1 and `halted`=1 after 16 FETCH cycles.
